// File: rtl/qlab5_nios2_oci_trace_capture_if.sv
// Trace-capture bus: trace/test-end inputs, read port and status outputs.
// The master drives trace and control; the slave (capture block) returns data and status.
interface qlab5_nios2_oci_trace_capture_if #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int STAT_W = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                    arm;
  logic                    dct_valid;
  logic [DATA_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]        dct_count;
  logic                    test_ending;
  logic                    test_has_ended;
  logic                    rd_req;
  logic [CNT_W+DATA_W-1:0] rd_data;
  logic                    rd_valid;
  logic [LVL_W-1:0]        fill_level;
  logic                    overflow;
  logic [STAT_W-1:0]       capture_cnt;
  logic [STAT_W-1:0]       drop_cnt;
  logic [1:0]              state;
  logic                    done;
  logic                    seq_err;

  modport master (
    output arm, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_req,
    input  rd_data, rd_valid, fill_level, overflow, capture_cnt, drop_cnt, state, done, seq_err
  );
  modport slave (
    input  arm, dct_valid, dct_buffer, dct_count, test_ending, test_has_ended, rd_req,
    output rd_data, rd_valid, fill_level, overflow, capture_cnt, drop_cnt, state, done, seq_err
  );
endinterface

// File: rtl/qlab5_nios2_oci_trace_capture.sv
// OCI debug-trace capture buffer with wrap/stop-on-full, drain FSM and statistics.
// Optional tag-sequence checker enabled by defining QLAB5_OCI_TRACE_SEQCHK_EN.
module qlab5_nios2_oci_trace_capture #(
  parameter int DATA_W = 30,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int WRAP   = 0,
  parameter int STAT_W = 16
) (
  input  logic clk,
  input  logic reset_n,
  qlab5_nios2_oci_trace_capture_if.slave bus
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int ENT_W = CNT_W + DATA_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_CAPTURE = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0]   lvl_q, lvl_d;
  logic [ENT_W-1:0]   rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               ovf_q, ovf_d, done_q, done_d;
  logic [STAT_W-1:0]  cap_q, cap_d, drop_q, drop_d;
  logic               pop, wr, full, drop, store;
  logic [ENT_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    lvl_d      = lvl_q;
    rd_data_d  = rd_data_q;
    ovf_d      = ovf_q;
    cap_d      = cap_q;
    drop_d     = drop_q;

    pop   = bus.rd_req && (lvl_q != '0);
    wr    = (state_q == S_CAPTURE) && bus.dct_valid;
    full  = (lvl_q == LVL_W'(DEPTH));
    drop  = wr && full && !pop;
    // In stop-on-full mode a dropped entry is never stored; in wrap mode it replaces the oldest.
    store = wr && !(drop && (WRAP == 0));

    rd_valid_d = pop;
    if (pop) begin
      rptr_d    = rptr_q + 1'b1;
      rd_data_d = mem_q[rptr_q];
    end
    if (store) wptr_d = wptr_q + 1'b1;
    if (drop && (WRAP != 0)) rptr_d = rptr_q + 1'b1;

    if (store && !pop && !drop) lvl_d = lvl_q + 1'b1;
    else if (pop && !store)     lvl_d = lvl_q - 1'b1;

    if (wr && (cap_q != '1))   cap_d  = cap_q + 1'b1;
    if (drop && (drop_q != '1)) drop_d = drop_q + 1'b1;
    if (drop) ovf_d = 1'b1;

    case (state_q)
      S_IDLE:    if (bus.test_ending) state_d = S_DRAIN;
                 else if (bus.arm)    state_d = S_CAPTURE;
      S_CAPTURE: if (bus.test_ending) state_d = S_DRAIN;
      S_DRAIN:   if ((lvl_q == '0) && bus.test_has_ended) state_d = S_DONE;
      default:   state_d = S_DONE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      lvl_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      cap_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      lvl_q      <= lvl_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      cap_q      <= cap_d;
      drop_q     <= drop_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the pointers and level.
  always_ff @(posedge clk) begin
    if (store) mem_q[wptr_q] <= {bus.dct_count, bus.dct_buffer};
  end

`ifdef QLAB5_OCI_TRACE_SEQCHK_EN
  logic [CNT_W-1:0] exp_tag_q, exp_tag_d;
  logic             seen_q, seen_d, seq_err_q, seq_err_d;

  // Every accepted trace beat advances the expected tag, including ones dropped on full.
  always_comb begin
    exp_tag_d = exp_tag_q;
    seen_d    = seen_q;
    seq_err_d = seq_err_q;
    if (wr) begin
      if (seen_q && (bus.dct_count != exp_tag_q)) seq_err_d = 1'b1;
      exp_tag_d = bus.dct_count + 1'b1;
      seen_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exp_tag_q <= '0;
      seen_q    <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      exp_tag_q <= exp_tag_d;
      seen_q    <= seen_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.fill_level  = lvl_q;
  assign bus.overflow    = ovf_q;
  assign bus.capture_cnt = cap_q;
  assign bus.drop_cnt    = drop_q;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_qlab5_nios2_oci_trace_capture.sv
// Directed bench: one stimulus stream drives a stop-on-full and a wrap instance,
// each checked against its own queue scoreboard.
module tb_qlab5_nios2_oci_trace_capture;
  localparam int DW = 30, CW = 4, D = 16, SW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  qlab5_nios2_oci_trace_capture_if #(.DATA_W(DW), .CNT_W(CW), .DEPTH(D), .STAT_W(SW)) b0 ();
  qlab5_nios2_oci_trace_capture_if #(.DATA_W(DW), .CNT_W(CW), .DEPTH(D), .STAT_W(SW)) b1 ();

  assign b1.arm            = b0.arm;
  assign b1.dct_valid      = b0.dct_valid;
  assign b1.dct_buffer     = b0.dct_buffer;
  assign b1.dct_count      = b0.dct_count;
  assign b1.test_ending    = b0.test_ending;
  assign b1.test_has_ended = b0.test_has_ended;
  assign b1.rd_req         = b0.rd_req;

  qlab5_nios2_oci_trace_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(D), .WRAP(0), .STAT_W(SW))
    u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  qlab5_nios2_oci_trace_capture #(.DATA_W(DW), .CNT_W(CW), .DEPTH(D), .WRAP(1), .STAT_W(SW))
    u1 (.clk(clk), .reset_n(reset_n), .bus(b1));

  logic [CW+DW-1:0] q0[$], q1[$];
  logic [CW+DW-1:0] erd0, erd1;
  bit               ev0, ev1, ovf0, ovf1, seqe, seen;
  int               cap, drop0, drop1;
  logic [1:0]       mst;
  logic [CW-1:0]    etag;
  int               npass = 0, nfail = 0, ntot = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit eseq;
`ifdef QLAB5_OCI_TRACE_SEQCHK_EN
    eseq = seqe;
`else
    eseq = 1'b0;
`endif
    chk("w0.fill_level", 64'(b0.fill_level), 64'(q0.size()));
    chk("w1.fill_level", 64'(b1.fill_level), 64'(q1.size()));
    chk("w0.rd_valid", 64'(b0.rd_valid), 64'(ev0));
    chk("w1.rd_valid", 64'(b1.rd_valid), 64'(ev1));
    chk("w0.rd_data", 64'(b0.rd_data), 64'(erd0));
    chk("w1.rd_data", 64'(b1.rd_data), 64'(erd1));
    chk("w0.state", 64'(b0.state), 64'(mst));
    chk("w1.state", 64'(b1.state), 64'(mst));
    chk("w0.done", 64'(b0.done), 64'(mst == 2'd3));
    chk("w1.done", 64'(b1.done), 64'(mst == 2'd3));
    chk("w0.overflow", 64'(b0.overflow), 64'(ovf0));
    chk("w1.overflow", 64'(b1.overflow), 64'(ovf1));
    chk("w0.capture_cnt", 64'(b0.capture_cnt), 64'(cap));
    chk("w1.capture_cnt", 64'(b1.capture_cnt), 64'(cap));
    chk("w0.drop_cnt", 64'(b0.drop_cnt), 64'(drop0));
    chk("w1.drop_cnt", 64'(b1.drop_cnt), 64'(drop1));
    chk("w0.seq_err", 64'(b0.seq_err), 64'(eseq));
    chk("w1.seq_err", 64'(b1.seq_err), 64'(eseq));
  endtask

  task automatic model_clear();
    q0.delete(); q1.delete();
    erd0 = '0; erd1 = '0; ev0 = 0; ev1 = 0; ovf0 = 0; ovf1 = 0;
    seqe = 0; seen = 0; etag = '0;
    cap = 0; drop0 = 0; drop1 = 0; mst = 2'd0;
  endtask

  // Asynchronous reset asserted immediately, released after the next edge.
  task automatic do_reset();
    b0.arm = 0; b0.dct_valid = 0; b0.dct_buffer = '0; b0.dct_count = '0;
    b0.test_ending = 0; b0.test_has_ended = 0; b0.rd_req = 0;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all();
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic step(input bit v, input logic [CW-1:0] tag, input bit rd,
                      input bit te, input bit th, input bit a);
    logic [DW-1:0]    d;
    logic [CW+DW-1:0] ent;
    int               lvl_pre;
    bit               pop0, pop1, wr;
    d = DW'($urandom);
    ent = {tag, d};
    b0.arm = a; b0.dct_valid = v; b0.dct_buffer = d; b0.dct_count = tag;
    b0.test_ending = te; b0.test_has_ended = th; b0.rd_req = rd;

    lvl_pre = q0.size();
    pop0 = rd && (q0.size() > 0);
    pop1 = rd && (q1.size() > 0);
    ev0 = pop0; ev1 = pop1;
    if (pop0) erd0 = q0.pop_front();
    if (pop1) erd1 = q1.pop_front();
    wr = v && (mst == 2'd1);
    if (wr) begin
      if (cap < 65535) cap++;
      if (q0.size() == D) begin drop0++; ovf0 = 1; end
      else q0.push_back(ent);
      if (q1.size() == D) begin void'(q1.pop_front()); drop1++; ovf1 = 1; end
      q1.push_back(ent);
      if (seen && (tag != etag)) seqe = 1;
      etag = tag + 1'b1;
      seen = 1;
    end
    case (mst)
      2'd0: if (te) mst = 2'd2; else if (a) mst = 2'd1;
      2'd1: if (te) mst = 2'd2;
      2'd2: if ((lvl_pre == 0) && th) mst = 2'd3;
      default: mst = 2'd3;
    endcase

    @(posedge clk); #1;
    b0.arm = 0; b0.dct_valid = 0; b0.test_ending = 0; b0.rd_req = 0;
    check_all();
  endtask

  initial begin
    model_clear();
    do_reset();

    // Basic capture and in-order drain.
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, CW'(i), 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);

    // Overfill: 20 writes, then full write+pop, then drain to DONE.
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) step(1, CW'(i), 0, 0, 0, 0);
    step(1, CW'(20), 1, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(1, CW'(i), 1, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 1, 1);

    // Reset mid-capture, then test_ending beats arm from IDLE.
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, CW'(i), 0, 0, 0, 0);
    do_reset();
    step(0, 0, 0, 1, 0, 1);

    // Beat coincident with test_ending still lands; later beats ignored.
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, CW'(i), 0, 0, 0, 0);
    step(1, CW'(3), 0, 1, 0, 0);
    step(1, CW'(4), 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);

    // Tag sequence gap 0,1,3.
    do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(1, CW'(0), 0, 0, 0, 0);
    step(1, CW'(1), 0, 0, 0, 0);
    step(1, CW'(3), 0, 0, 0, 0);
    step(1, CW'(4), 1, 0, 0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
